// File: rtl/sprite_scanline_renderer_pkg.sv
// Shared definitions for the sprite scanline renderer: default geometry,
// FSM state encoding and the 9-bit sprite row helper.
package sprite_scanline_renderer_pkg;

  localparam int H_DISPLAY_DEF = 256;
  localparam int SPRITE_W_DEF  = 8;
  localparam int SPRITE_H_DEF  = 16;
  localparam int ROM_AW_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ARMED = 3'd3,
    ST_DRAW  = 3'd4
  } state_e;

  // Row of the sprite that lands on the next scanline. Wraps modulo 512, so a
  // sprite whose top is below the next line gives a large, non-matching row.
  function automatic logic [8:0] sprite_row(input logic [8:0] vpos,
                                            input logic [8:0] sprite_y);
    return vpos + 9'd1 - sprite_y;
  endfunction

endpackage

// File: rtl/sprite_scanline_renderer_if.sv
// Beam, sprite-position, ROM and pixel signals of the sprite scanline renderer.
// Optional build macro SPRITE_HMIRROR_EN adds the hmirror input.
interface sprite_scanline_renderer_if
  import sprite_scanline_renderer_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int ROM_AW   = ROM_AW_DEF
);

  logic [8:0]          hpos;
  logic [8:0]          vpos;
  logic                display_on;
  logic                vsync;
  logic [8:0]          sprite_x;
  logic [8:0]          sprite_y;
`ifdef SPRITE_HMIRROR_EN
  logic                hmirror;
`endif
  logic [ROM_AW-1:0]   rom_addr;
  logic [SPRITE_W-1:0] rom_bits;
  logic                gfx;
  logic                busy;

  // Beam generator, sprite control and ROM side.
  modport master (
`ifdef SPRITE_HMIRROR_EN
    output hmirror,
`endif
    output hpos, vpos, display_on, vsync, sprite_x, sprite_y, rom_bits,
    input  rom_addr, gfx, busy
  );

  // Renderer side.
  modport slave (
`ifdef SPRITE_HMIRROR_EN
    input  hmirror,
`endif
    input  hpos, vpos, display_on, vsync, sprite_x, sprite_y, rom_bits,
    output rom_addr, gfx, busy
  );

endinterface

// File: rtl/sprite_scanline_renderer_row_shifter.sv
// Holds one fetched sprite row and serialises it. A start emits the first
// bit and arms the bit counter; each shift emits the next bit. done_o marks
// the shift that consumes the last bit. dir_i (sampled on dir_we_i) selects
// LSB-first output for a horizontally mirrored row.
module sprite_scanline_renderer_row_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         start_i,
  input  logic         shift_i,
  input  logic         dir_we_i,
  input  logic         dir_i,
  output logic         bit_o,
  output logic         done_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;

  // Next row contents, remaining-bit count and output direction.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dir_d   = dir_we_i ? dir_i : dir_q;
    if (load_i) begin
      shift_d = data_i;
    end else if (start_i || shift_i) begin
      shift_d = dir_q ? (shift_q >> 1) : (shift_q << 1);
      cnt_d   = start_i ? CW'(W - 1) : cnt_q - CW'(1);
    end
  end

  // Row, counter and direction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign bit_o  = dir_q ? shift_q[0] : shift_q[W-1];
  assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/sprite_scanline_renderer.sv
// Single monochrome hardware sprite renderer. At the start of horizontal
// blanking it decides whether the next scanline crosses the sprite, fetches
// that bitmap row from a registered ROM, then shifts it out as gfx when the
// beam reaches the sprite's left edge. gfx lags the beam by one pixel.
// Optional build macro SPRITE_HMIRROR_EN enables horizontal mirroring.
module sprite_scanline_renderer
  import sprite_scanline_renderer_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int SPRITE_W  = SPRITE_W_DEF,
  parameter int SPRITE_H  = SPRITE_H_DEF,
  parameter int ROM_AW    = ROM_AW_DEF
) (
  input logic                      clk,
  input logic                      reset,
  sprite_scanline_renderer_if.slave bus
);

  localparam logic [8:0] H_END    = 9'(H_DISPLAY);
  localparam logic [8:0] SPRITE_H9 = 9'(SPRITE_H);

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [8:0]        x_q, x_d;
  logic              gfx_q, gfx_d;
  logic              busy_q, busy_d;

  logic              sh_load, sh_start, sh_shift, sh_sample;
  logic              sh_bit, sh_done;
  logic              sh_dir;

  logic              hblank;
  logic [8:0]        row;
  logic              row_hit;
  logic              x_match;

  assign hblank  = (bus.hpos == H_END);
  assign row     = sprite_row(bus.vpos, bus.sprite_y);
  assign row_hit = (row < SPRITE_H9);
  assign x_match = (bus.hpos == x_q) && bus.display_on;

`ifdef SPRITE_HMIRROR_EN
  assign sh_dir = bus.hmirror;
`else
  assign sh_dir = 1'b0;
`endif

  sprite_scanline_renderer_row_shifter #(
    .W (SPRITE_W)
  ) u_row_shifter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (sh_load),
    .data_i   (bus.rom_bits),
    .start_i  (sh_start),
    .shift_i  (sh_shift),
    .dir_we_i (sh_sample),
    .dir_i    (sh_dir),
    .bit_o    (sh_bit),
    .done_o   (sh_done)
  );

  // State, ROM address, latched x, gfx and busy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      x_q        <= '0;
      gfx_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      x_q        <= x_d;
      gfx_q      <= gfx_d;
      busy_q     <= busy_d;
    end
  end

  // Next state. vsync abandons whatever is in flight; an ARMED sprite that
  // never matched (off-screen x or blank line) is re-evaluated at hblank.
  always_comb begin
    state_d = state_q;
    if (bus.vsync) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (hblank && row_hit) state_d = ST_FETCH;
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_ARMED;
        ST_ARMED: begin
          if (hblank)       state_d = row_hit ? ST_FETCH : ST_IDLE;
          else if (x_match) state_d = ST_DRAW;
        end
        ST_DRAW:  if (sh_done) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and datapath controls: hblank sampling, row load and bit emission.
  always_comb begin
    rom_addr_d = rom_addr_q;
    x_d        = x_q;
    gfx_d      = 1'b0;
    sh_load    = 1'b0;
    sh_start   = 1'b0;
    sh_shift   = 1'b0;
    sh_sample  = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    if (!bus.vsync) begin
      case (state_q)
        ST_IDLE: begin
          if (hblank && row_hit) begin
            rom_addr_d = row[ROM_AW-1:0];
            x_d        = bus.sprite_x;
            sh_sample  = 1'b1;
          end
        end
        ST_LOAD: sh_load = 1'b1;
        ST_ARMED: begin
          if (hblank) begin
            if (row_hit) begin
              rom_addr_d = row[ROM_AW-1:0];
              x_d        = bus.sprite_x;
              sh_sample  = 1'b1;
            end
          end else if (x_match) begin
            sh_start = 1'b1;
            gfx_d    = sh_bit & bus.display_on;
          end
        end
        ST_DRAW: begin
          sh_shift = 1'b1;
          gfx_d    = sh_bit & bus.display_on;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.gfx      = gfx_q;
  assign bus.busy     = busy_q;

endmodule
